// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem read, valid/ready handoff to decode.
// Optional IFETCH_STALL_CNT_EN adds a saturating stall_cnt output counting WAIT and back-pressured HOLD cycles.
module instr_fetch #(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef IFETCH_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              imem_req_q, imem_req_d;
  logic              inst_valid_q, inst_valid_d;

  // Next-state, PC and capture logic; req/valid are registered from the next state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        state_d = WAIT;
        if (redirect) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = REQ;
            if (redirect) pc_d = redirect_pc;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + ADDR_W'(1);
            state_d   = HOLD;
          end
        end else if (redirect) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (inst_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    imem_req_d   = (state_d == REQ);
    inst_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign opcode     = inst_q[31:26];
  assign inst_pc    = inst_pc_q;

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_inc_c;

  // Saturating count of memory-wait and decode back-pressure cycles.
  always_comb begin
    stall_inc_c = (state_q == WAIT) ||
                  ((state_q == HOLD) && !inst_ready && !redirect);
    stall_cnt_d = stall_cnt_q;
    if (stall_inc_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the KGP-RISC core: holds the program counter, issues one word read at a time to instruction memory, and presents the fetched 32-bit instruction, its 6-bit opcode and its PC to the decode/control stage through a valid/ready handshake. It sits directly upstream of the opcode decoder. It accepts PC redirects from the branch logic and discards any fetch made on the wrong path.

## Interface
- `ADDR_W`, 32: PC and instruction-memory address width. Addresses are word addresses.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `imem_req` out 1: read request to instruction memory. Valid for one cycle.
- `imem_addr` out ADDR_W: read address. Equals `pc` while `imem_req` is 1.
- `imem_rvalid` in 1: read data valid. Arrives at least one cycle after `imem_req`.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: `inst`, `opcode` and `inst_pc` are valid for decode.
- `inst_ready` in 1: decode accepts the instruction.
- `inst` out 32: fetched instruction.
- `opcode` out 6: `inst[31:26]`.
- `inst_pc` out ADDR_W: address `inst` was fetched from.
- `redirect` in 1: taken branch or jump. Single-cycle pulse.
- `redirect_pc` in ADDR_W: new fetch target. Sampled when `redirect` is 1.

## Operation
- State register states are IDLE, REQ, WAIT and HOLD. Internal registers are `pc` and a `drop` flag.
- **Reset** (asynchronous) sets:
  - state to IDLE, `pc` to RESET_PC, `drop` to 0;
  - `inst`, `opcode` and `inst_pc` to 0;
  - `inst_valid` and `imem_req` to 0.
- **IDLE**: always goes to REQ. This gives a clean first request after reset release.
- **REQ**:
  - `imem_req` is 1 and `imem_addr` is `pc`.
  - Goes to WAIT unconditionally.
  - If `redirect` is 1, `pc` loads `redirect_pc` and `drop` is set to 1.
- **WAIT**: waits for `imem_rvalid`.
  - `imem_rvalid`=1 and `drop`=0 and no `redirect`:
    - `inst` loads `imem_rdata`;
    - `inst_pc` loads `pc`;
    - `pc` loads `pc+1`;
    - go to HOLD.
  - `imem_rvalid`=1 and (`drop`=1 or `redirect`=1): discard the data and clear `drop`. If `redirect`, `pc` loads `redirect_pc`. Go to REQ.
  - `imem_rvalid`=0 and `redirect`=1: `pc` loads `redirect_pc`, set `drop`, stay in WAIT.
- **HOLD**: `inst_valid` is 1.
  - `redirect`=1 (priority over `inst_ready`): `pc` loads `redirect_pc` and go to REQ. The held instruction is not consumed.
  - Otherwise `inst_ready`=1: go to REQ.
  - Otherwise stay; `inst`, `opcode` and `inst_pc` are held stable.
- **PC arithmetic**: `pc+1` is modulo 2^ADDR_W. At all-ones the PC wraps to 0 with no flag.
- **Outstanding requests**: at most one is ever in flight. `imem_rvalid` outside WAIT is ignored.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `inst_ready`, `redirect` or `imem_rvalid` to any output.
- Fixed-latency memory (`imem_rvalid` one cycle after `imem_req`) with `inst_ready` tied high:
  - request at cycle t, data at t+1, `inst_valid` at t+2, next request at t+3;
  - throughput is 1 instruction per 3 cycles.
- Each extra memory wait cycle adds 1 cycle. Each cycle of `inst_ready`=0 in HOLD adds 1 cycle.
- Redirect latency:
  - a redirect in HOLD gives a request to `redirect_pc` on the next cycle;
  - a redirect in REQ or WAIT gives a request to `redirect_pc` one cycle after the pending response returns.
- `rst_n` asserted mid-operation clears state immediately. A response returning after reset release is ignored because the state is not WAIT.

## Configuration
- `IFETCH_STALL_CNT_EN` defined:
  - adds output `stall_cnt` (32 bits, reset 0);
  - increments on every cycle in WAIT, and every cycle in HOLD with `inst_ready`=0 and `redirect`=0;
  - saturates at 32'hFFFFFFFF and never wraps.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- **Reset and first fetch**: RESET_PC=0x10, memory returns 0x3A000000 one cycle after the request.
  - `imem_addr`=0x10 in the first REQ.
  - `inst_valid` with `opcode`=6'b001110 and `inst_pc`=0x10.
  - Next request to 0x11.
- **Back-pressure**: hold `inst_ready`=0 for 5 cycles in HOLD.
  - `inst`, `opcode` and `inst_pc` stay stable with no new `imem_req`.
  - `stall_cnt` rises by 5 when `IFETCH_STALL_CNT_EN` is defined.
- **Redirect in HOLD**: `redirect`=1, `redirect_pc`=0x40, `inst_ready`=1 in the same cycle.
  - The instruction is not re-presented.
  - The next `imem_addr` is 0x40.
- **Redirect in WAIT**: pulse `redirect` (`redirect_pc`=0x80) before `imem_rvalid`, with 3-cycle memory latency.
  - The returned word is dropped and `inst_valid` stays 0.
  - The next request is to 0x80.
- **Wrap-around**: ADDR_W=8, RESET_PC=0xFF.
  - After the first accept, the next `imem_addr` is 0x00.
- **Async reset**: drop `rst_n` in WAIT.
  - `inst_valid` and `imem_req` go to 0 immediately.
  - A stray `imem_rvalid` after release is ignored and the fetch restarts at RESET_PC.
